// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the EX pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SAD = 1'b1
    } sad_state_e;

    localparam logic [1:0] MEMREAD_NONE = 2'b00;
    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         NUM_EX       = 3;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex1_bubble;
        logic ex1ex2_write;
        logic ex2ex3_bubble;
        logic flush_ifid;
        logic flush_idex1;
        logic flush_ex1ex2;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_OFF    = '0;
    localparam pipe_ctl_t CTL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, idex1_bubble: 1'b0,
                                         ex1ex2_write: 1'b1, ex2ex3_bubble: 1'b0,
                                         flush_ifid: 1'b0, flush_idex1: 1'b0, flush_ex1ex2: 1'b0};

    // A destination matches an ID source only for a real register; $zero never hazards.
    function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
        return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare of the ID sources against the loads in EX1..EX3.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0]                rs_id,
    input  logic [4:0]                rt_id,
    input  logic                      uses_rt_id,
    input  logic [NUM_EX-1:0][1:0]    mem_read,
    input  logic [NUM_EX-1:0][4:0]    reg_dst,
    output logic                      load_hz
);

    logic [NUM_EX-1:0] stage_hit;

    for (genvar k = 0; k < NUM_EX; k++) begin : g_stage
        assign stage_hit[k] = (mem_read[k] != MEMREAD_NONE) &&
                              src_hit(reg_dst[k], rs_id, rt_id, uses_rt_id);
    end

    assign load_hz = |stage_hit;

endmodule

// File: rtl/ex_pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, multi-cycle SAD freeze in EX2, EX3 jump flushes,
// plus saturating stall/flush cycle counters.
module ex_pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SAD_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             uses_rt_ID,
    input  logic [1:0]       MemRead_EX1,
    input  logic [1:0]       MemRead_EX2,
    input  logic [1:0]       MemRead_EX3,
    input  logic [4:0]       RegDst1Result_EX1,
    input  logic [4:0]       RegDst1Result_EX2,
    input  logic [4:0]       RegDst1Result_EX3,
    input  logic             sad_EX2,
    input  logic             Jump_EX3,
    input  logic             JR_EX3,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX1_Bubble,
    output logic             EX1EX2_Write,
    output logic             EX2EX3_Bubble,
    output logic             Flush_IFID,
    output logic             Flush_IDEX1,
    output logic             Flush_EX1EX2,
    output logic             sad_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int        SCNT_W   = (SAD_CYCLES > 2) ? $clog2(SAD_CYCLES - 1) : 1;
    localparam bit        SAD_MULTI = (SAD_CYCLES > 1);
    localparam logic [SCNT_W-1:0] SAD_INIT = (SAD_CYCLES > 2) ? SCNT_W'(SAD_CYCLES - 2) : '0;

    sad_state_e        state_q;
    logic [SCNT_W-1:0] cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_hz, flush, sad_stall;
    pipe_ctl_t         ctl;

    load_use_detect u_lud (
        .rs_id      (rs_ID),
        .rt_id      (rt_ID),
        .uses_rt_id (uses_rt_ID),
        .mem_read   ({MemRead_EX3, MemRead_EX2, MemRead_EX1}),
        .reg_dst    ({RegDst1Result_EX3, RegDst1Result_EX2, RegDst1Result_EX1}),
        .load_hz    (load_hz)
    );

    assign flush     = Jump_EX3 | JR_EX3;
    assign sad_stall = ((state_q == RUN) && sad_EX2 && SAD_MULTI) ||
                       ((state_q == SAD) && (cnt_q != '0));

    // Reset forces every enable low without waiting for a clock edge.
    always_comb begin
        ctl = CTL_NORMAL;
        if (flush) begin
            ctl.flush_ifid   = 1'b1;
            ctl.flush_idex1  = 1'b1;
            ctl.flush_ex1ex2 = 1'b1;
        end else if (sad_stall) begin
            ctl.pc_write      = 1'b0;
            ctl.ifid_write    = 1'b0;
            ctl.ex1ex2_write  = 1'b0;
            ctl.ex2ex3_bubble = 1'b1;
        end else if (load_hz) begin
            ctl.pc_write     = 1'b0;
            ctl.ifid_write   = 1'b0;
            ctl.idex1_bubble = 1'b1;
        end
        if (!Reset) ctl = CTL_OFF;
    end

    assign PCWrite       = ctl.pc_write;
    assign IFID_Write    = ctl.ifid_write;
    assign IDEX1_Bubble  = ctl.idex1_bubble;
    assign EX1EX2_Write  = ctl.ex1ex2_write;
    assign EX2EX3_Bubble = ctl.ex2ex3_bubble;
    assign Flush_IFID    = ctl.flush_ifid;
    assign Flush_IDEX1   = ctl.flush_idex1;
    assign Flush_EX1EX2  = ctl.flush_ex1ex2;
    assign sad_busy      = (state_q == SAD);

    // cnt counts the remaining stall cycles; the cnt==0 cycle lets EX2/EX3 capture the result.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: if (sad_EX2 && SAD_MULTI) begin
                    state_q <= SAD;
                    cnt_q   <= SAD_INIT;
                end
                SAD: if (cnt_q != '0) cnt_q <= cnt_q - SCNT_W'(1);
                     else             state_q <= RUN;
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctl.pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != '1))         flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
